// File: rtl/vproc_div_block.sv
// vproc_div_block: 32-bit unsigned divider with optional operand, divider-output
// and result register stages.
//   clk_i      - rising-edge clock
//   sync_rst_i - synchronous active-high reset, clears every enabled stage
//   mod        - 0 selects the quotient, 1 the remainder (aligned to the select stage)
//   op1_i      - dividend
//   op2_i      - divisor (0 yields quotient all-ones, remainder op1)
//   res_o      - selected quotient or remainder
package vproc_pkg;
    typedef enum logic [0:0] {DIV_GENERIC, DIV_ALT} div_type;
endpackage

module vproc_div_block #(
    parameter vproc_pkg::div_type DIV_TYPE = vproc_pkg::DIV_GENERIC,
    parameter bit                 BUF_OPS  = 1'b1,
    parameter bit                 BUF_DIV  = 1'b1,
    parameter bit                 BUF_RES  = 1'b0
) (
    input  logic        clk_i,
    input  logic        sync_rst_i,
    input  logic        mod,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    output logic [31:0] res_o
);
    logic [31:0] op1_d, op2_d, op1_q, op2_q, op1, op2;
    logic [31:0] quo_d, rem_d, quo_q, rem_q, quo, rem;
    logic [31:0] res_d, res_q;

    always_comb begin
        op1_d = op1_i;
        op2_d = op2_i;
    end

    assign op1 = BUF_OPS ? op1_q : op1_d;
    assign op2 = BUF_OPS ? op2_q : op2_d;

    generate
        if (DIV_TYPE == vproc_pkg::DIV_GENERIC) begin : g_restoring
            // Restoring array: the bit shifted out of the partial remainder acts as
            // the 33rd bit, so a divisor of 0 naturally gives all-ones / op1.
            always_comb begin
                quo_d = '0;
                rem_d = '0;
                for (int i = 31; i >= 0; i--) begin
                    quo_d[i] = rem_d[31] | ({rem_d[30:0], op1[i]} >= op2);
                    rem_d    = {rem_d[30:0], op1[i]} - (quo_d[i] ? op2 : '0);
                end
            end
        end else begin : g_operator
            always_comb begin
                quo_d = (op2 == '0) ? '1  : op1 / op2;
                rem_d = (op2 == '0) ? op1 : op1 % op2;
            end
        end
    endgenerate

    assign quo = BUF_DIV ? quo_q : quo_d;
    assign rem = BUF_DIV ? rem_q : rem_d;

    always_comb begin
        res_d = mod ? rem : quo;
    end

    assign res_o = BUF_RES ? res_q : res_d;

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            op1_q <= '0;
            op2_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            res_q <= '0;
        end else begin
            op1_q <= op1_d;
            op2_q <= op2_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            res_q <= res_d;
        end
    end
endmodule

// File: tb/tb_vproc_div_block.sv
// tb_vproc_div_block: random and directed checks of all buffer/divider configurations
module tb_vproc_div_block;
    localparam int N  = 10100;
    localparam int R  = 5000;
    localparam int NC = 16;

    logic        clk_i = 1'b0;
    logic        sync_rst_i = 1'b1;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic        mod_v [NC];
    logic [31:0] res_v [NC];

    logic [31:0] op1_h [N];
    logic [31:0] op2_h [N];
    bit          md_h  [N];
    bit          rst_h [N];
    logic [31:0] dir_exp [11];

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < NC; g++) begin : g_dut
        vproc_div_block #(
            .DIV_TYPE(g >= 8 ? vproc_pkg::DIV_ALT : vproc_pkg::DIV_GENERIC),
            .BUF_OPS (bit'(g & 1)),
            .BUF_DIV (bit'((g >> 1) & 1)),
            .BUF_RES (bit'((g >> 2) & 1))
        ) dut (
            .clk_i     (clk_i),
            .sync_rst_i(sync_rst_i),
            .mod       (mod_v[g]),
            .op1_i     (op1_i),
            .op2_i     (op2_i),
            .res_o     (res_v[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit m);
        if (b == 0) return m ? a : 32'hFFFF_FFFF;
        return m ? a % b : a / b;
    endfunction

    function automatic int lat(input int c);
        return (c & 1) + ((c >> 1) & 1) + ((c >> 2) & 1);
    endfunction

    function automatic int sel(input int c);
        return (c & 1) + ((c >> 1) & 1);
    endfunction

    // An operand survives only if no reset edge falls among the edges it is registered on.
    function automatic bit valid(input int s, input int l);
        if (s < 0) return 1'b0;
        for (int k = s; k < s + l; k++) if (rst_h[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic set_dir(input int s, input logic [31:0] a, input logic [31:0] b, input bit m,
                           input logic [31:0] e);
        op1_h[s] = a;
        op2_h[s] = b;
        md_h[s]  = m;
        dir_exp[s-2] = e;
    endtask

    initial begin
        int s, l, pick;
        logic [31:0] exp;
        for (int t = 0; t < N; t++) begin
            pick = int'($urandom_range(0, 7));
            op1_h[t] = (pick == 1) ? $urandom_range(0, 64) : $urandom;
            op2_h[t] = (pick == 0) ? 32'd0 : (pick == 2) ? $urandom_range(1, 16) :
                       (pick == 3) ? 32'd1 : $urandom >> $urandom_range(0, 31);
            md_h[t]  = bit'($urandom_range(0, 1));
            rst_h[t] = (t < 2) || (t == R);
        end
        set_dir(2,  32'd100, 32'd7, 1'b0, 32'd14);
        set_dir(3,  32'd100, 32'd7, 1'b1, 32'd2);
        set_dir(4,  32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF);
        set_dir(5,  32'd5, 32'd0, 1'b1, 32'd5);
        set_dir(6,  32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF);
        set_dir(7,  32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0);
        set_dir(8,  32'd3, 32'h8000_0000, 1'b0, 32'd0);
        set_dir(9,  32'd3, 32'h8000_0000, 1'b1, 32'd3);
        set_dir(10, 32'd20, 32'd3, 1'b0, 32'd6);
        set_dir(11, 32'd21, 32'd3, 1'b0, 32'd7);
        set_dir(12, 32'd22, 32'd3, 1'b0, 32'd7);
        for (int c = 0; c < NC; c++) mod_v[c] = 1'b0;
        for (int t = 0; t < N; t++) begin
            @(posedge clk_i);
            #1;
            sync_rst_i = rst_h[t];
            op1_i = op1_h[t];
            op2_i = op2_h[t];
            for (int c = 0; c < NC; c++) begin
                s = t - sel(c);
                mod_v[c] = (s >= 0) ? md_h[s] : 1'b0;
            end
            @(negedge clk_i);
            for (int c = 0; c < NC; c++) begin
                l = lat(c);
                s = t - l;
                if (t > 0 && rst_h[t-1] && (c & 6) != 0) begin
                    check($sformatf("reset_zero cfg%0d t%0d", c, t), res_v[c], 32'd0);
                end else if (valid(s, l)) begin
                    exp = (s >= 2 && s <= 12) ? dir_exp[s-2] : ref_div(op1_h[s], op2_h[s], md_h[s]);
                    check($sformatf("%s cfg%0d t%0d", (s >= 2 && s <= 12) ? "directed" : "random", c, t),
                          res_v[c], exp);
                end
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vproc_div_block.md
VPROC_DIV_BLOCK -- requirements
Module: vproc_div_block

Interface
REQ-001 The block SHALL have parameter DIV_TYPE, type vproc_pkg::div_type, default DIV_GENERIC, selecting the divider implementation style.
REQ-002 The block SHALL have parameter BUF_OPS, 1-bit, default 1, which adds an operand register stage.
REQ-003 The block SHALL have parameter BUF_DIV, 1-bit, default 1, which adds a divider-output register stage.
REQ-004 The block SHALL have parameter BUF_RES, 1-bit, default 0, which adds a result register stage.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all registers are rising-edge.
REQ-006 The block SHALL have port sync_rst_i, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port mod, input, 1 bit: 0 selects quotient, 1 selects remainder.
REQ-008 The block SHALL have port op1_i, input, 32 bits: dividend, unsigned.
REQ-009 The block SHALL have port op2_i, input, 32 bits: divisor, unsigned.
REQ-010 The block SHALL have port res_o, output, 32 bits: selected quotient or remainder.

Function
REQ-011 The block SHALL compute both q = op1/op2 and r = op1 mod op2 as 32-bit unsigned integer division, with truncation.
REQ-012 Divide by zero (op2 = 0) SHALL yield q = 0xFFFFFFFF and r = op1, with no exception flag.
REQ-013 Results SHALL satisfy op1 = q*op2 + r and r < op2 for every op2 != 0.
REQ-014 The pipeline SHALL be, in order: optional BUF_OPS register (op1, op2) -> divider -> optional BUF_DIV register (q, r) -> mod select -> optional BUF_RES register (selected result) -> res_o.
REQ-015 Each enabled stage SHALL add exactly one cycle; when a stage is disabled it is a combinational pass-through.
REQ-016 Operand-to-res_o latency SHALL be BUF_OPS + BUF_DIV + BUF_RES cycles (0 = fully combinational).
REQ-017 mod SHALL be sampled at the select point, i.e. BUF_OPS + BUF_DIV cycles after the corresponding operands (the caller supplies mod time-aligned to that stage).
REQ-018 The pipeline SHALL be free-running: there is no valid/ready/enable, every enabled register loads on every clock edge, and a new operand pair may be accepted each cycle.
REQ-019 The divider core SHALL be combinational for DIV_GENERIC (e.g. a 32-step restoring array); every other DIV_TYPE value SHALL produce bit-identical results with identical latency.
REQ-020 Signed division SHALL NOT be handled internally; the caller pre-extends operands to 32 bits.

Reset
REQ-021 While sync_rst_i = 1 at a clock edge, every enabled pipeline register SHALL clear to 0.
REQ-022 With BUF_RES = 1, or with BUF_DIV = 1 and BUF_RES = 0, res_o SHALL read 0x00000000 in the cycle after reset.
REQ-023 With all buffers disabled, res_o SHALL follow the inputs combinationally regardless of reset.
REQ-024 Reset asserted mid-stream SHALL discard every in-flight result; the first valid output after deassertion corresponds to operands applied at or after the deassertion edge, after the full latency.

Verification
REQ-025 Defaults (latency 2): op1 = 100, op2 = 7, with mod = 0 two cycles later -> res_o = 14; with mod = 1 -> res_o = 2.
REQ-026 op1 = 5, op2 = 0 -> q = 0xFFFFFFFF, r = 5.
REQ-027 op1 = 0xFFFFFFFF, op2 = 1 -> q = 0xFFFFFFFF, r = 0; op1 = 3, op2 = 0x80000000 -> q = 0, r = 3.
REQ-028 BUF_OPS = BUF_DIV = BUF_RES = 1, back-to-back pairs (20,3), (21,3), (22,3) with mod = 0 -> res_o = 6, 7, 7 on cycles 3, 4, 5.
REQ-029 Assert sync_rst_i for one cycle mid-stream -> res_o = 0 on the next cycle; results of operands applied before reset never appear.
REQ-030 Random self-check: 10k random pairs including op2 = 0, in all 8 buffer configurations -> every result matches the REQ-011/REQ-012 reference model at the REQ-016 latency.
